// File: rtl/tl45_wbarb_n.sv
// N-master pipelined Wishbone arbiter with registered ownership, outstanding-request limit and bus-timeout abort.
// Define TL45_WBARB_RR_EN for round-robin arbitration; otherwise lowest requesting index wins.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | no owner, all masters stalled, arbitrating among i_m_cyc
//   S_OWNED | o_grant owner drives the slave port, responses routed to it
//   S_ABORT | owner timed out; slave port idle until the owner drops cyc
module tl45_wbarb_n #(
    parameter int NM      = 3,
    parameter int DW      = 32,
    parameter int AW      = 30,
    parameter int MAXOUT  = 7,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NM-1:0]     i_m_cyc,
    input  logic [NM-1:0]     i_m_stb,
    input  logic [NM-1:0]     i_m_we,
    input  logic [NM*AW-1:0]  i_m_adr,
    input  logic [NM*DW-1:0]  i_m_dat,
    input  logic [NM*DW/8-1:0] i_m_sel,
    output logic [NM-1:0]     o_m_ack,
    output logic [NM-1:0]     o_m_stall,
    output logic [NM-1:0]     o_m_err,
    output logic              o_cyc,
    output logic              o_stb,
    output logic              o_we,
    output logic [AW-1:0]     o_adr,
    output logic [DW-1:0]     o_dat,
    output logic [DW/8-1:0]   o_sel,
    input  logic              i_ack,
    input  logic              i_stall,
    input  logic              i_err,
    output logic [NM-1:0]     o_grant
);

    localparam int SW    = DW / 8;
    localparam int IW    = (NM > 1) ? $clog2(NM) : 1;
    localparam int CW    = $clog2(MAXOUT + 1);
    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWNED,
        S_ABORT
    } state_t;

    state_t        state;
    logic [IW-1:0] own_idx;
    logic [CW-1:0] out_cnt;
    logic [TW-1:0] timer;

    logic          owned;
    logic          own_cyc;
    logic          at_max;
    logic          timed_out;
    logic          accept;
    logic          resp;
    logic          dec;

    logic          win_vld;
    logic [IW-1:0] win_idx;
    logic [NM-1:0] win_oh;

    assign owned     = (state == S_OWNED);
    assign own_cyc   = i_m_cyc[own_idx];
    assign at_max    = (out_cnt == CW'(MAXOUT));
    assign timed_out = TO_EN && owned && (out_cnt != '0) && (timer == TW'(TIMEOUT));
    assign accept    = o_stb && !i_stall;
    assign resp      = i_ack || i_err;
    // Stray responses with nothing outstanding must not wrap the counter.
    assign dec       = resp && (out_cnt != '0);

`ifdef TL45_WBARB_RR_EN
    logic [IW-1:0] rr_ptr;
    int            cand;

    // Later (smaller) offsets overwrite earlier ones, so the first requester after rr_ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int off = NM; off >= 1; off--) begin
            cand = (int'(rr_ptr) + off) % NM;
            if (i_m_cyc[cand]) begin
                win_vld = 1'b1;
                win_idx = IW'(cand);
            end
        end
    end
`else
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NM - 1; i >= 0; i--) begin
            if (i_m_cyc[i]) begin
                win_vld = 1'b1;
                win_idx = IW'(i);
            end
        end
    end
`endif

    always_comb begin
        win_oh          = '0;
        win_oh[win_idx] = win_vld;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= S_IDLE;
            o_grant <= '0;
            own_idx <= '0;
            out_cnt <= '0;
            timer   <= '0;
`ifdef TL45_WBARB_RR_EN
            rr_ptr  <= IW'(NM - 1);
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    out_cnt <= '0;
                    timer   <= '0;
                    if (win_vld) begin
                        state   <= S_OWNED;
                        own_idx <= win_idx;
                        o_grant <= win_oh;
`ifdef TL45_WBARB_RR_EN
                        rr_ptr  <= win_idx;
`endif
                    end
                end
                S_OWNED: begin
                    if (!own_cyc) begin
                        state   <= S_IDLE;
                        o_grant <= '0;
                        out_cnt <= '0;
                        timer   <= '0;
                    end else if (timed_out) begin
                        state   <= S_ABORT;
                        out_cnt <= '0;
                        timer   <= '0;
                    end else begin
                        if (accept && !dec)
                            out_cnt <= out_cnt + 1'b1;
                        else if (!accept && dec)
                            out_cnt <= out_cnt - 1'b1;

                        if (accept || resp)
                            timer <= '0;
                        else if (TO_EN && (out_cnt != '0) && (timer != TW'(TIMEOUT)))
                            timer <= timer + 1'b1;
                    end
                end
                S_ABORT: begin
                    out_cnt <= '0;
                    timer   <= '0;
                    if (!own_cyc) begin
                        state   <= S_IDLE;
                        o_grant <= '0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    o_grant <= '0;
                end
            endcase
        end
    end

    // Slave-side mux and response routing; everything is gated by the registered state,
    // so reset silences the bus without waiting for a clock edge.
    always_comb begin
        o_m_ack   = '0;
        o_m_err   = '0;
        o_m_stall = '1;
        o_cyc     = 1'b0;
        o_stb     = 1'b0;
        o_we      = 1'b0;
        o_adr     = '0;
        o_dat     = '0;
        o_sel     = '0;
        if (owned) begin
            o_we  = i_m_we[own_idx];
            o_adr = i_m_adr[own_idx*AW +: AW];
            o_dat = i_m_dat[own_idx*DW +: DW];
            o_sel = i_m_sel[own_idx*SW +: SW];
            if (timed_out) begin
                o_m_err[own_idx] = 1'b1;
            end else begin
                o_cyc              = own_cyc;
                o_stb              = own_cyc && i_m_stb[own_idx] && !at_max;
                o_m_stall[own_idx] = i_stall || at_max;
                o_m_ack[own_idx]   = i_ack;
                o_m_err[own_idx]   = i_err;
            end
        end
    end

endmodule
